// File: rtl/mux_scan_n_pkg.sv
// mux_scan_n_pkg: shared definitions for the scan/direct multiplexer.
//   st_e        controller state (DIRECT / SCAN), exposed for debug
//   MODE_*      values of the mode input
//   clog2_min1  ceil(log2(n)) clamped to at least 1 bit
package mux_scan_n_pkg;

    typedef enum logic {
        ST_DIRECT = 1'b0,
        ST_SCAN   = 1'b1
    } st_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_scan_n_if.sv
// mux_scan_n_if: channel inputs, output stream and control of mux_scan_n.
//   in_data/in_valid/in_ready  per-channel inputs, channel c at [c*WIDTH +: WIDTH]
//   mode/sel                   0 = direct (sel picks channel), 1 = scan
//   out_data/out_valid/out_ready/out_ch  registered output stream
//   sel_err                    direct mode with sel >= NCH
//   state                      controller state, for debug
//   out_par                    even parity of out_data (only with MUX_PARITY_EN)
// Handshake: a word moves when valid & ready are both high at a rising clk
// edge; valid may not depend on ready, and a producer holds data stable while
// valid is high and ready is low.
interface mux_scan_n_if
    import mux_scan_n_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int NCH   = 5
);
    localparam int SEL_W = clog2_min1(NCH);

    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SEL_W-1:0]     sel;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SEL_W-1:0]     out_ch;
    logic                 sel_err;
    st_e                  state;
`ifdef MUX_PARITY_EN
    logic                 out_par;
`endif

    // Multiplexer side.
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch, sel_err, state
`ifdef MUX_PARITY_EN
        , out_par
`endif
    );

    // Environment side: drives channels and control, consumes the output.
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch, sel_err, state
`ifdef MUX_PARITY_EN
        , out_par
`endif
    );

endinterface

// File: rtl/mux_scan_n_rr_pointer.sv
// mux_scan_n_rr_pointer: channel pointer with dwell counter.
//   clk, rst_n  clock, async active-low reset
//   scan_en     scan mode active; dwell counter is cleared otherwise
//   xfer        a word was accepted from cur_ch this cycle
//   skip        move on immediately (current channel has nothing to send)
//   load        direct-mode load of load_ch (takes priority)
//   cur_ch      current channel
module mux_scan_n_rr_pointer
    import mux_scan_n_pkg::*;
#(
    parameter int NCH   = 5,
    parameter int DWELL = 4,
    parameter int SEL_W = clog2_min1(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_en,
    input  logic             xfer,
    input  logic             skip,
    input  logic             load,
    input  logic [SEL_W-1:0] load_ch,
    output logic [SEL_W-1:0] cur_ch
);
    localparam int CNT_W = clog2_min1(DWELL);

    logic [CNT_W-1:0] dwell_cnt;
    logic [SEL_W-1:0] next_ch;
    logic             dwell_done;

    assign next_ch    = (cur_ch == SEL_W'(NCH - 1)) ? '0 : cur_ch + SEL_W'(1);
    // The transfer happening now is the DWELL-th on this channel.
    assign dwell_done = xfer && (dwell_cnt == CNT_W'(DWELL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_ch    <= '0;
            dwell_cnt <= '0;
        end else if (load) begin
            cur_ch    <= load_ch;
            dwell_cnt <= '0;
        end else if (!scan_en) begin
            // Direct mode with an illegal select: hold the channel.
            dwell_cnt <= '0;
        end else if (skip || dwell_done) begin
            cur_ch    <= next_ch;
            dwell_cnt <= '0;
        end else if (xfer) begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux_scan_n.sv
// mux_scan_n: NCH-channel, WIDTH-bit registered multiplexer with valid/ready
// flow control, in direct (sel-driven) or scan (round-robin, DWELL transfers
// per channel) mode.
//   clk, rst_n  clock, async active-low reset
//   bus         mux_scan_n_if.slave (see interface header for signals)
// Optional feature: define MUX_PARITY_EN to add bus.out_par = ^out_data,
// registered alongside out_data.
module mux_scan_n
    import mux_scan_n_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int NCH   = 5,
    parameter int DWELL = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    mux_scan_n_if.slave bus
);
    localparam int SEL_W = clog2_min1(NCH);

    st_e              state;
    logic             sel_err_q;
    logic [SEL_W-1:0] cur_ch;
    logic [NCH-1:0]   ch_onehot;
    logic [WIDTH-1:0] cur_data;
    logic             cur_valid;
    logic             can_accept;
    logic             accept;
    logic             sel_ok;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic [SEL_W-1:0] out_ch_q;

    assign sel_ok = int'(bus.sel) < NCH;

    always_comb begin
        ch_onehot = '0;
        cur_data  = '0;
        for (int c = 0; c < NCH; c++) begin
            ch_onehot[c] = (cur_ch == SEL_W'(c));
            if (cur_ch == SEL_W'(c)) cur_data = bus.in_data[c*WIDTH +: WIDTH];
        end
    end

    // Output register is free or draining this cycle, and no select error.
    assign can_accept   = (!out_valid_q || bus.out_ready) && !sel_err_q;
    assign cur_valid    = |(bus.in_valid & ch_onehot);
    assign accept       = cur_valid && can_accept;
    assign bus.in_ready = ch_onehot & {NCH{can_accept}};

    mux_scan_n_rr_pointer #(
        .NCH   (NCH),
        .DWELL (DWELL),
        .SEL_W (SEL_W)
    ) u_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .scan_en (bus.mode == MODE_SCAN),
        .xfer    (accept),
        .skip    ((bus.mode == MODE_SCAN) && !cur_valid),
        .load    ((bus.mode == MODE_DIRECT) && sel_ok),
        .load_ch (bus.sel),
        .cur_ch  (cur_ch)
    );

    // Mode controller: state and sel_err follow the mode/sel inputs one cycle late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_DIRECT;
            sel_err_q <= 1'b0;
        end else if (bus.mode == MODE_SCAN) begin
            state     <= ST_SCAN;
            sel_err_q <= 1'b0;
        end else begin
            state     <= ST_DIRECT;
            sel_err_q <= !sel_ok;
        end
    end

    // Output register: replace on accept (covers drain+accept with no bubble),
    // empty on drain-only, hold during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
        end else if (accept) begin
            out_data_q  <= cur_data;
            out_valid_q <= 1'b1;
            out_ch_q    <= cur_ch;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef MUX_PARITY_EN
    logic out_par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par_q <= 1'b0;
        end else if (accept) begin
            out_par_q <= ^cur_data;
        end
    end

    assign bus.out_par = out_par_q;
`endif

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.sel_err   = sel_err_q;
    assign bus.state     = state;

endmodule
